// File: rtl/multicycle_control_unit_if.sv
// Control-unit <-> datapath/memory bundle for the multi-cycle MIPS core.
//  master : control unit (consumes instr/hits/ALU flags, drives requests,
//           enables, datapath selects, register selects and status)
//  slave  : datapath / memory side
//  instr, i_hit, d_hit, zero_f, overflow_f      datapath -> control
//  i_ren, d_ren, d_wen, ir_en, pc_en, PCSrc,
//  alu_op, ALUSrc, ExtOP, rsel1, rsel2, wsel,
//  wen, W_mux, halt, mem_err, state              control -> datapath
interface multicycle_control_unit_if;
  logic [31:0] instr;
  logic        i_hit, d_hit, zero_f, overflow_f;
  logic        i_ren, d_ren, d_wen, ir_en, pc_en;
  logic [1:0]  PCSrc;
  logic [3:0]  alu_op;
  logic [1:0]  ALUSrc;
  logic        ExtOP;
  logic [4:0]  rsel1, rsel2, wsel;
  logic        wen;
  logic [2:0]  W_mux;
  logic        halt, mem_err;
  logic [2:0]  state;

  modport master (
    input  instr, i_hit, d_hit, zero_f, overflow_f,
    output i_ren, d_ren, d_wen, ir_en, pc_en, PCSrc, alu_op, ALUSrc, ExtOP,
           rsel1, rsel2, wsel, wen, W_mux, halt, mem_err, state
  );
  modport slave (
    output instr, i_hit, d_hit, zero_f, overflow_f,
    input  i_ren, d_ren, d_wen, ir_en, pc_en, PCSrc, alu_op, ALUSrc, ExtOP,
           rsel1, rsel2, wsel, wen, W_mux, halt, mem_err, state
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB/HALT sequencing,
// datapath select generation, IR capture, imem/dmem request handshakes,
// memory wait timeout (mem_err), optional signed-overflow trap, sticky halt.
//  CLK  : clock, rising edge
//  nRST : synchronous reset, active low
//  bus  : multicycle_control_unit_if.master (see interface header)
// Encodings: PCSrc ADD4=0 JUMP=1 JR=2 BRANCH=3; ALUSrc RDAT2=0 SHAMT=1 EXT=2;
// ExtOP ZEROEXT=0 SIGNEXT=1; W_mux R31=0 LUI=1 DATA=2 ALUOUT=3;
// alu_op SLL=0 SRL=1 ADD=2 SUB=3 AND=4 OR=5 XOR=6 NOR=7 SLT=8 SLTU=9.
module multicycle_control_unit #(
  parameter int          WAIT_MAX    = 16,
  parameter bit          TRAP_ON_OVF = 1'b1,
  parameter logic [31:0] HALT_WORD   = 32'hFFFF_FFFF
) (
  input logic CLK,
  input logic nRST,
  multicycle_control_unit_if.master bus
);
  typedef enum logic [2:0] {FETCH=3'd0, DECODE=3'd1, EXEC=3'd2, MEM=3'd3, WB=3'd4, HALT=3'd5} state_t;
  typedef enum logic [3:0] {K_ALU, K_LUI, K_LW, K_SW, K_J, K_JAL, K_JR, K_BEQ, K_BNE} kind_t;

  localparam logic [1:0] PC_ADD4 = 2'd0, PC_JUMP = 2'd1, PC_JR = 2'd2, PC_BR = 2'd3;
  localparam logic [1:0] SRC_RDAT2 = 2'd0, SRC_SHAMT = 2'd1, SRC_EXT = 2'd2;
  localparam logic       ZEROEXT = 1'b0, SIGNEXT = 1'b1;
  localparam logic [2:0] W_R31 = 3'd0, W_LUI = 3'd1, W_DATA = 3'd2, W_ALU = 3'd3;
  localparam logic [3:0] A_SLL = 4'd0, A_SRL = 4'd1, A_ADD = 4'd2, A_SUB = 4'd3, A_AND = 4'd4,
                         A_OR = 4'd5, A_XOR = 4'd6, A_NOR = 4'd7, A_SLT = 4'd8, A_SLTU = 4'd9;
  localparam int CW = $clog2(WAIT_MAX + 1);

  state_t      st, nxt;
  logic [31:0] ir;
  logic [CW-1:0] wcnt;
  logic        halt_r, err_r;

  logic [5:0]  op, fn;
  kind_t       kind;
  logic        valid, ovf_chk;
  logic [3:0]  alu;
  logic [1:0]  asrc;
  logic        ext;

  logic        i_ren, d_ren, d_wen, ir_en, pc_en, wen, timeout;
  logic [1:0]  pcsrc;

  assign op = ir[31:26];
  assign fn = ir[5:0];

  // Instruction decode, always from the latched IR
  always_comb begin
    valid = 1'b1; kind = K_ALU; alu = A_ADD; asrc = SRC_RDAT2; ext = SIGNEXT; ovf_chk = 1'b0;
    case (op)
      6'h00: case (fn)
        6'h00: begin alu = A_SLL; asrc = SRC_SHAMT; end
        6'h02: begin alu = A_SRL; asrc = SRC_SHAMT; end
        6'h08: kind = K_JR;
        6'h20: begin alu = A_ADD; ovf_chk = 1'b1; end
        6'h21: alu = A_ADD;
        6'h22: begin alu = A_SUB; ovf_chk = 1'b1; end
        6'h23: alu = A_SUB;
        6'h24: alu = A_AND;
        6'h25: alu = A_OR;
        6'h26: alu = A_XOR;
        6'h27: alu = A_NOR;
        6'h2A: alu = A_SLT;
        6'h2B: alu = A_SLTU;
        default: valid = 1'b0;
      endcase
      6'h02: kind = K_J;
      6'h03: kind = K_JAL;
      6'h04: begin kind = K_BEQ; alu = A_SUB; end
      6'h05: begin kind = K_BNE; alu = A_SUB; end
      6'h08: begin asrc = SRC_EXT; ovf_chk = 1'b1; end
      6'h09: asrc = SRC_EXT;
      6'h0A: begin alu = A_SLT;  asrc = SRC_EXT; end
      6'h0B: begin alu = A_SLTU; asrc = SRC_EXT; end
      6'h0C: begin alu = A_AND;  asrc = SRC_EXT; ext = ZEROEXT; end
      6'h0D: begin alu = A_OR;   asrc = SRC_EXT; ext = ZEROEXT; end
      6'h0E: begin alu = A_XOR;  asrc = SRC_EXT; ext = ZEROEXT; end
      6'h0F: begin kind = K_LUI; asrc = SRC_EXT; end
      6'h23: begin kind = K_LW;  asrc = SRC_EXT; end
      6'h2B: begin kind = K_SW;  asrc = SRC_EXT; end
      default: valid = 1'b0;
    endcase
  end

  // Next state and per-state strobes
  always_comb begin
    nxt = st; i_ren = 1'b0; d_ren = 1'b0; d_wen = 1'b0; ir_en = 1'b0; pc_en = 1'b0;
    wen = 1'b0; pcsrc = PC_ADD4; timeout = 1'b0;
    case (st)
      FETCH: begin
        i_ren = 1'b1;
        if (bus.i_hit) begin
          ir_en = 1'b1; pc_en = 1'b1; nxt = DECODE;
        end else if (wcnt == CW'(WAIT_MAX - 1)) begin
          timeout = 1'b1; nxt = HALT;
        end
      end
      DECODE: begin
        if (ir == HALT_WORD) nxt = HALT;
        else if (!valid)     nxt = FETCH;
        else                 nxt = EXEC;
      end
      EXEC: begin
        case (kind)
          K_J:   begin pc_en = 1'b1; pcsrc = PC_JUMP; nxt = FETCH; end
          K_JR:  begin pc_en = 1'b1; pcsrc = PC_JR;   nxt = FETCH; end
          K_JAL: begin pc_en = 1'b1; pcsrc = PC_JUMP; nxt = WB;    end
          K_BEQ: begin pc_en = bus.zero_f;  pcsrc = PC_BR; nxt = FETCH; end
          K_BNE: begin pc_en = !bus.zero_f; pcsrc = PC_BR; nxt = FETCH; end
          K_LW, K_SW: nxt = MEM;
          K_LUI: nxt = WB;
          default: nxt = (TRAP_ON_OVF && ovf_chk && bus.overflow_f) ? HALT : WB;
        endcase
      end
      MEM: begin
        d_ren = (kind == K_LW);
        d_wen = (kind == K_SW);
        if (bus.d_hit) nxt = (kind == K_LW) ? WB : FETCH;
        else if (wcnt == CW'(WAIT_MAX - 1)) begin
          timeout = 1'b1; nxt = HALT;
        end
      end
      WB: begin wen = 1'b1; nxt = FETCH; end
      HALT: nxt = HALT;
      default: nxt = FETCH;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      st <= FETCH; ir <= '0; wcnt <= '0; halt_r <= 1'b0; err_r <= 1'b0;
    end else begin
      st <= nxt;
      if (ir_en) ir <= bus.instr;
      // Counter restarts on every state change, so it only accumulates while
      // FETCH/MEM sit waiting for a hit.
      if (nxt != st) wcnt <= '0;
      else if (st == FETCH || st == MEM) wcnt <= wcnt + CW'(1);
      if (nxt == HALT) halt_r <= 1'b1;
      if (timeout)     err_r  <= 1'b1;
    end
  end

  // Strobes are masked while reset is held so an aborted instruction never commits
  assign bus.i_ren   = nRST & i_ren;
  assign bus.d_ren   = nRST & d_ren;
  assign bus.d_wen   = nRST & d_wen;
  assign bus.ir_en   = nRST & ir_en;
  assign bus.pc_en   = nRST & pc_en;
  assign bus.wen     = nRST & wen;
  assign bus.PCSrc   = pcsrc;
  assign bus.alu_op  = alu;
  assign bus.ALUSrc  = asrc;
  assign bus.ExtOP   = ext;
  assign bus.rsel1   = ir[25:21];
  assign bus.rsel2   = ir[20:16];
  assign bus.wsel    = (kind == K_JAL) ? 5'd31 : (op == 6'h00) ? ir[15:11] : ir[20:16];
  assign bus.W_mux   = (kind == K_JAL) ? W_R31 : (kind == K_LUI) ? W_LUI :
                       (kind == K_LW) ? W_DATA : W_ALU;
  assign bus.halt    = halt_r;
  assign bus.mem_err = err_r;
  assign bus.state   = st;
endmodule
